// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin arbiter sharing one UART transmit byte channel
//             among NREQ byte-stream requesters. A requester keeps the
//             channel for a whole burst (terminated by its last flag), with
//             a lock timeout for stalled owners and a sent-byte counter.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int CNT_W        = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [8*NREQ-1:0]         req_byte,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    output logic                      out_valid,
    output logic [7:0]                out_byte,
    input  logic                      uart_ready,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [CNT_W-1:0]          bytes_sent
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic            last_q;
    logic [TW-1:0]   lock_cnt;

    logic            grant_any;
    logic [IW-1:0]   grant_idx;
    logic [IW:0]     cand;
    logic            take;
    logic [IW-1:0]   take_idx;
    logic [7:0]      take_byte;
    logic            take_last;
    logic            xfer;
    logic [IW-1:0]   next_ptr;

    // Round-robin search: scan offsets high to low so the closest index to
    // rr_ptr (smallest offset) is the one left standing.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (req_valid[cand[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    // Decide whether a requester byte is captured this cycle and from whom.
    always_comb begin
        xfer     = out_valid & uart_ready;
        take     = 1'b0;
        take_idx = owner;
        case (state)
            S_IDLE: begin
                take     = grant_any;
                take_idx = grant_idx;
            end
            S_SEND:   take = xfer & ~last_q & req_valid[owner];
            S_LOCKED: take = req_valid[owner];
            default:  take = 1'b0;
        endcase
        // A byte offered during reset is never acknowledged.
        if (RST) begin
            take = 1'b0;
        end
        take_byte = req_byte[{take_idx, 3'b000} +: 8];
        take_last = req_last[take_idx];
        next_ptr  = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end

    // One-hot acknowledge towards the captured requester only.
    always_comb begin
        req_ready = '0;
        if (take) begin
            req_ready[take_idx] = 1'b1;
        end
    end

    // Burst-lock state machine with registered channel outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            out_valid   <= 1'b0;
            out_byte    <= 8'h00;
            owner       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            bytes_sent  <= '0;
            rr_ptr      <= '0;
            lock_cnt    <= '0;
            last_q      <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        out_byte  <= take_byte;
                        last_q    <= take_last;
                        owner     <= take_idx;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        bytes_sent <= bytes_sent + 1'b1;
                        if (last_q) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            rr_ptr    <= next_ptr;
                            state     <= S_IDLE;
                        end else if (take) begin
                            out_byte <= take_byte;
                            last_q   <= take_last;
                        end else begin
                            out_valid <= 1'b0;
                            lock_cnt  <= '0;
                            state     <= S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    if (take) begin
                        out_byte  <= take_byte;
                        last_q    <= take_last;
                        out_valid <= 1'b1;
                        lock_cnt  <= '0;
                        state     <= S_SEND;
                    end else if (lock_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        rr_ptr      <= next_ptr;
                        state       <= S_IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Randomized bench for uart_tx_arbiter with a transaction-level
//             reference model of burst locking, round-robin order, lock
//             timeout and the sent-byte counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int LT   = 16;
    localparam int CW   = 4;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [8*NREQ-1:0]   req_byte  = '0;
    logic [NREQ-1:0]     req_last  = '0;
    logic [NREQ-1:0]     req_ready;
    logic                out_valid;
    logic [7:0]          out_byte;
    logic                uart_ready = 1'b0;
    logic [1:0]          owner;
    logic                busy;
    logic                timeout_err;
    logic [CW-1:0]       bytes_sent;

    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_byte(req_byte), .req_last(req_last),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_byte(out_byte), .uart_ready(uart_ready),
        .owner(owner), .busy(busy), .timeout_err(timeout_err),
        .bytes_sent(bytes_sent)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Requester side
    bit        hold [NREQ];
    logic [7:0] hbyte [NREQ];
    bit        hlast [NREQ];
    int        seq [NREQ];

    // Stimulus controls
    int              mode = 0;
    logic [NREQ-1:0] mask = '0;
    int              p_valid = 0, p_last = 30, p_ur = 50;
    int              ur_mode = 0, age = 0;
    bit              ur_force = 0, rst_drive = 1, r3_granted = 0;
    int              tmo_obs = 0;

    // Reference model: is a burst lock held, by whom, is a byte presented
    bit         m_locked = 0, m_pending = 0, m_plast = 0, m_tmo_next = 0, m_fresh = 0;
    int         m_owner = 0, m_rr = 0, m_wait = 0, m_sent = 0;
    logic [7:0] m_pbyte = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_locked = 0; m_pending = 0; m_plast = 0; m_tmo_next = 0;
        m_owner = 0; m_rr = 0; m_wait = 0; m_sent = 0;
    endtask

    task automatic gen(input int i);
        case (mode)
            0: if (seq[i] < 2) begin
                hbyte[i] = 8'h61 + 8'(seq[i]); hlast[i] = (seq[i] == 1);
                hold[i] = 1; seq[i]++;
            end
            2: begin
                hbyte[i] = 8'($urandom); hlast[i] = (seq[i] % 2 == 1);
                hold[i] = 1; seq[i]++;
            end
            3: if (i == 3) begin
                if (seq[3] == 0) begin
                    hbyte[3] = 8'($urandom); hlast[3] = 0; hold[3] = 1; seq[3]++;
                end
            end else if (r3_granted) begin
                hbyte[i] = 8'($urandom); hlast[i] = ($urandom_range(99) < p_last);
                hold[i] = 1;
            end
            default: begin
                hbyte[i] = 8'($urandom); hlast[i] = ($urandom_range(99) < p_last);
                hold[i] = 1;
            end
        endcase
    endtask

    task automatic observe();
        bit              consume, was_pend;
        int              widx;
        logic [NREQ-1:0] exp_rdy;
        consume = m_pending && uart_ready;
        check("busy", busy, m_locked);
        check("out_valid", out_valid, m_pending);
        if (m_pending) check("out_byte", out_byte, m_pbyte);
        check("bytes_sent", bytes_sent, m_sent % (1 << CW));
        check("timeout_err", timeout_err, m_tmo_next);
        if (m_locked) check("owner", owner, m_owner);
        if (m_fresh) begin
            check("owner_rst", owner, 0);
            check("out_byte_rst", out_byte, 0);
        end
        m_fresh = 0;
        if (timeout_err) tmo_obs++;
        if (RST) begin
            check("ready_in_rst", req_ready, 0);
            model_reset();
            m_fresh = 1;
            return;
        end
        widx = -1;
        if (!m_locked) begin
            for (int k = 0; k < NREQ; k++)
                if (widx < 0 && req_valid[(m_rr + k) % NREQ]) widx = (m_rr + k) % NREQ;
        end else if (!m_pending) begin
            if (req_valid[m_owner]) widx = m_owner;
        end else if (consume && !m_plast && req_valid[m_owner]) begin
            widx = m_owner;
        end
        exp_rdy = '0;
        if (widx >= 0) exp_rdy[widx] = 1'b1;
        check("req_ready", req_ready, exp_rdy);

        was_pend   = m_pending;
        m_tmo_next = 0;
        if (consume) begin
            m_sent++;
            m_pending = 0;
            if (m_plast) begin
                m_locked = 0; m_rr = (m_owner + 1) % NREQ;
            end else m_wait = 0;
        end
        if (widx >= 0) begin
            m_pending = 1; m_pbyte = req_byte[widx*8 +: 8]; m_plast = req_last[widx];
            m_locked = 1; m_owner = widx; m_wait = 0;
        end else if (m_locked && !was_pend) begin
            m_wait++;
            if (m_wait == LT) begin
                m_locked = 0; m_rr = (m_owner + 1) % NREQ; m_tmo_next = 1;
            end
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) hold[i] = 0;
        if (mode == 3 && req_ready[3]) r3_granted = 1;
        if (consume) age = 0;
    endtask

    task automatic step();
        @(posedge CLK); #1;
        RST = rst_drive;
        for (int i = 0; i < NREQ; i++)
            if (!hold[i] && mask[i] && $urandom_range(99) < p_valid) gen(i);
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = hold[i];
            req_byte[i*8 +: 8] = hold[i] ? hbyte[i] : 8'h00;
            req_last[i] = hold[i] ? hlast[i] : 1'b0;
        end
        if (out_valid) age++; else age = 0;
        if (ur_force) uart_ready = 1'b1;
        else if (ur_mode == 1) uart_ready = out_valid && (age == 3);
        else uart_ready = out_valid && ($urandom_range(99) < p_ur);
        @(negedge CLK);
        observe();
    endtask

    task automatic drain();
        mode = 9; mask = '0; p_ur = 100; ur_mode = 0;
        repeat (60) step();
    endtask

    initial begin
        bit found;
        int tmo_base;
        for (int i = 0; i < NREQ; i++) begin
            hold[i] = 0; hbyte[i] = 8'h00; hlast[i] = 0; seq[i] = 0;
        end
        repeat (3) step();
        rst_drive = 0;

        // Single requester, "a" then "b"(last), slow uart
        mode = 0; mask = 4'b0100; p_valid = 100; ur_mode = 1;
        repeat (30) step();
        ur_mode = 0;
        drain();

        // Two continuously valid requesters, two-byte bursts
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
        mode = 2; mask = 4'b0011; p_valid = 100; p_ur = 50;
        repeat (200) step();
        drain();

        // Owner 3 stalls mid-burst while requester 0 waits
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
        r3_granted = 0; tmo_base = tmo_obs;
        mode = 3; mask = 4'b1001; p_valid = 100; p_ur = 70;
        repeat (120) step();
        check("lock_timeouts", tmo_obs - tmo_base, 1);
        check("req3_granted", r3_granted, 1);
        drain();

        // Random traffic, then sparse traffic that provokes timeouts
        mode = 4; mask = 4'b1111; p_valid = 30; p_last = 35; p_ur = 60;
        repeat (1500) step();
        p_valid = 8;
        repeat (1500) step();
        drain();

        // Reset while a byte is being presented and consumed
        mode = 4; mask = 4'b1111; p_valid = 100; p_ur = 0; found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (out_valid) found = 1;
        end
        check("wait_out_valid", found, 1);
        rst_drive = 1; ur_force = 1;
        step();
        rst_drive = 0; ur_force = 0; p_ur = 60;
        repeat (100) step();
        drain();

        // uart_ready with nothing to send
        mode = 9; mask = '0; ur_force = 1;
        repeat (10) step();
        ur_force = 0;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmit byte channel between NREQ byte-stream requesters. Each requester sends bursts (messages) terminated by a last flag. The arbiter locks the channel to one requester for a whole burst so messages never interleave on the serial line. It sits between the requesting blocks and the uart module's byte-input handshake ({valid, byte} out, ready pulse back), and adds a lock timeout and a sent-byte counter.

Parameters:
NREQ, 4, number of requesters (2..8); owner index width IW = clog2(NREQ).
LOCK_TIMEOUT, 1024, idle cycles a locked owner may stall mid-burst before the lock is forcibly released.
CNT_W, 16, width of the sent-byte counter.

Ports:
CLK  input  1  clock; all state updates on posedge.
RST  input  1  synchronous, active-high reset.
req_valid  input  NREQ  requester i has a byte on req_byte[8i+7:8i].
req_byte  input  8*NREQ  packed request bytes.
req_last  input  NREQ  requester i's current byte ends its burst.
req_ready  output  NREQ  one-hot, one-cycle pulse: byte of requester i captured this cycle.
out_valid  output  1  byte channel to uart valid.
out_byte  output  8  byte channel to uart data.
uart_ready  input  1  one-cycle pulse from uart: current out_byte consumed.
owner  output  IW  index of the locked requester (valid when busy=1).
busy  output  1  a burst is in progress.
timeout_err  output  1  one-cycle pulse when a lock is forcibly released.
bytes_sent  output  CNT_W  count of bytes consumed by the uart, wraps modulo 2^CNT_W.

Behaviour:
- Reset (RST=1 at posedge): state=IDLE, out_valid=0, out_byte=0, req_ready=0, owner=0, busy=0, timeout_err=0, bytes_sent=0, rr_ptr=0, timeout counter=0. Reset mid-burst drops any pending byte silently; no req_ready is issued for it.
- The transfer to the uart occurs on a cycle where out_valid=1 and uart_ready=1. uart_ready while out_valid=0 is ignored.
- out_valid and out_byte are registered. A byte captured at cycle t is presented from t+1.
- FSM states:
  - IDLE: busy=0. Search req_valid starting at rr_ptr, wrapping modulo NREQ. The first set index i wins. Same cycle: req_ready[i]=1, latch req_byte[i] and req_last[i] (last_q). Next state is SEND with owner=i and busy=1. If no request, stay in IDLE.
  - SEND: out_valid=1. Wait for uart_ready. On uart_ready, bytes_sent increments and:
    - last_q=1: out_valid=0, rr_ptr=(owner+1) mod NREQ, go to IDLE. Re-arbitration starts the following cycle, so there is a one-cycle bubble between bursts.
    - last_q=0 and req_valid[owner]=1: capture the owner's next byte in the same cycle (req_ready[owner]=1). Stay in SEND with no bubble.
    - last_q=0 and req_valid[owner]=0: out_valid=0, go to LOCKED, clear the timeout counter.
  - LOCKED: busy=1, out_valid=0, other requesters are not granted.
    - If req_valid[owner]=1: capture it, go to SEND, clear the counter.
    - Otherwise increment the counter. When it reaches LOCK_TIMEOUT-1 without a capture: pulse timeout_err, rr_ptr=(owner+1) mod NREQ, go to IDLE.
- req_ready is only ever asserted for the owner (or the IDLE winner). It is never asserted for two requesters at once.
- A requester's req_valid/req_byte/req_last must hold until its req_ready pulse. The arbiter never samples a non-owner mid-burst.
- Single-byte burst: req_last=1 on the first byte gives IDLE→SEND→IDLE.
- bytes_sent at 2^CNT_W-1 wraps to 0.

Test Plan:
- NREQ=4, only req 2 valid with bytes "a","b"(last), uart_ready pulsed 3 cycles after each out_valid rise. Expect req_ready[2] pulses twice; out_byte 0x61 then 0x62; busy falls after the second consume; rr_ptr=3; bytes_sent=2.
- Reqs 0 and 1 both continuously valid, 2-byte bursts each. Expect grant order 0,0,1,1,0,0, with no interleaving and a one-cycle bubble between bursts.
- Req 3 locks, sends a non-last byte, then drops req_valid while req 0 is valid. Expect no req_ready[0] and timeout_err exactly LOCK_TIMEOUT cycles after entering LOCKED. Then expect req 0 granted next.
- Owner re-asserts req_valid in the same cycle as uart_ready. Expect capture that cycle and out_valid continuously high (back-to-back bytes).
- Assert RST while in SEND with out_valid=1 and uart_ready pulsing. Expect all outputs reset values the next cycle, no further uart transfer, and bytes_sent=0.
- Drive uart_ready=1 while in IDLE with no requests. Expect no state change and bytes_sent unchanged.
